mem_sequencer: RTL and testbench

Fetch/execute step sequencer for the memory block. It drives the address-bus and memory-bus control selects, and the address-counter increment and decrement strobes, one micro-step per clock. Each step is sequenced from the opcode held in the instruction register. It sits between the instruction register output and the memory block control inputs, and is the only driver of those inputs.

---
 rtl/mem_seq_pkg.sv | 67 ++++++
 rtl/mem_sequencer_rom.sv | 41 ++++
 rtl/mem_sequencer.sv | 117 +++++++++++
 tb/tb_mem_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_seq_pkg.sv
// Shared definitions for the memory-block step sequencer: select codes,
// microword layout, control bundle and FSM states.
package mem_seq_pkg;

  localparam logic [2:0] SEL_TX        = 3'd0;
  localparam logic [2:0] SEL_SDP       = 3'd1;
  localparam logic [2:0] SEL_ACALC     = 3'd2;
  localparam logic [2:0] SEL_SP        = 3'd3;
  localparam logic [2:0] SEL_LR        = 3'd4;
  localparam logic [2:0] SEL_PC        = 3'd5;
  localparam logic [2:0] SEL_ADDR_NONE = 3'd7;

  localparam logic [3:0] SEL_NONE = 4'd0;
  localparam logic [3:0] SEL_IR   = 4'd8;
  localparam logic [3:0] SEL_MEM  = 4'd9;
  localparam logic [3:0] SEL_TXL  = 4'd11;
  localparam logic [3:0] SEL_TXH  = 4'd12;

  localparam int WORD_W    = 18;
  localparam int LOAD_LSB  = 0;
  localparam int OUT_LSB   = 4;
  localparam int ALOAD_LSB = 8;
  localparam int AOUT_LSB  = 11;
  localparam int INC_BIT   = 14;
  localparam int DEC_BIT   = 15;
  localparam int END_BIT   = 16;
  localparam int HALT_BIT  = 17;

  typedef logic [WORD_W-1:0] uword_t;

  localparam uword_t IDLE_WORD = {4'b0000, SEL_ADDR_NONE, SEL_ADDR_NONE, SEL_NONE, SEL_NONE};
  localparam uword_t NOP_WORD  = IDLE_WORD | (uword_t'(1) << END_BIT);

  typedef enum logic [2:0] {RESET, FETCH, DECODE, EXEC, HALT} state_t;

  typedef struct packed {
    logic [2:0] addrout;
    logic [2:0] addrload;
    logic [3:0] outs;
    logic [3:0] load;
    logic       incn;
    logic       decn;
  } ctl_t;

  localparam ctl_t CTL_IDLE  = '{SEL_ADDR_NONE, SEL_ADDR_NONE, SEL_NONE, SEL_NONE, 1'b1, 1'b1};
  localparam ctl_t CTL_FETCH = '{SEL_PC, SEL_ADDR_NONE, SEL_MEM, SEL_IR, 1'b0, 1'b1};

  function automatic uword_t mk_word(input logic [2:0] aout, input logic [2:0] aload,
                                     input logic [3:0] outs, input logic [3:0] load,
                                     input logic inc, input logic dec,
                                     input logic last, input logic halt);
    return {halt, last, dec, inc, aout, aload, outs, load};
  endfunction

  // inc wins when both strobes are requested
  function automatic ctl_t word_ctl(input uword_t w);
    ctl_t c;
    c.addrout  = w[AOUT_LSB +: 3];
    c.addrload = w[ALOAD_LSB +: 3];
    c.outs     = w[OUT_LSB +: 4];
    c.load     = w[LOAD_LSB +: 4];
    c.incn     = ~w[INC_BIT];
    c.decn     = ~(w[DEC_BIT] & ~w[INC_BIT]);
    return c;
  endfunction

endpackage

// File: rtl/mem_sequencer_rom.sv
// Microcode table: (opcode, step) -> microword. Anything not listed is a
// single-step NOP.
module microcode_rom
  import mem_seq_pkg::*;
#(
  parameter int         STEP_W     = 3,
  parameter logic [7:0] HLT_OPCODE = 8'hFF
) (
  input  logic [7:0]        opcode,
  input  logic [STEP_W-1:0] step,
  output uword_t            word
);

  localparam logic [STEP_W-1:0] S0 = '0;
  localparam logic [STEP_W-1:0] S1 = STEP_W'(1);

  always_comb begin
    word = NOP_WORD;
    if (opcode == HLT_OPCODE) begin
      if (step == S0) word[HALT_BIT] = 1'b1;
    end else begin
      case (opcode)
        8'h01: begin
          case (step)
            S0:      word = mk_word(SEL_PC, SEL_ADDR_NONE, SEL_MEM, SEL_TXL, 1'b1, 1'b0, 1'b0, 1'b0);
            S1:      word = mk_word(SEL_PC, SEL_ADDR_NONE, SEL_MEM, SEL_TXH, 1'b1, 1'b0, 1'b0, 1'b0);
            default: word = mk_word(SEL_TX, SEL_PC, SEL_NONE, SEL_NONE, 1'b0, 1'b0, 1'b1, 1'b0);
          endcase
        end
        // runs until the forced end on the last step
        8'h02:   word = mk_word(SEL_SP, SEL_ADDR_NONE, SEL_NONE, SEL_NONE, 1'b1, 1'b1, 1'b0, 1'b0);
        8'h03: begin
          if (step == S0) word = mk_word(SEL_SP, SEL_ADDR_NONE, SEL_NONE, SEL_NONE, 1'b0, 1'b1, 1'b0, 1'b0);
          else            word = mk_word(SEL_SP, SEL_ADDR_NONE, SEL_MEM, SEL_TXL, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        default: word = NOP_WORD;
      endcase
    end
  end

endmodule

// File: rtl/mem_sequencer.sv
// Fetch/decode/execute micro-step sequencer driving the memory block selects.
// state  | meaning
// RESET  | one idle cycle after rst
// FETCH  | PC onto address bus, MEM -> IR, PC increment
// DECODE | idle; registers step-0 word from iout
// EXEC   | issues registered word for current step
// HALT   | idle until rst
module mem_sequencer
  import mem_seq_pkg::*;
#(
  parameter int         MAX_STEPS  = 8,
  parameter logic [7:0] HLT_OPCODE = 8'hFF,
  localparam int        STEP_W     = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        iout,
  input  logic              stall,
  output logic [2:0]        addroutctl,
  output logic [2:0]        addrloadctl,
  output logic [3:0]        outctl,
  output logic [3:0]        loadctl,
  output logic              acincn,
  output logic              acdecn,
  output logic [STEP_W-1:0] step,
  output logic              fetching,
  output logic              halted
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS - 1);

  state_t            state;
  uword_t            word_q;
  uword_t            rom_word;
  ctl_t              ctl;
  logic              held;
  logic [7:0]        opcode_q;
  logic [7:0]        rom_op;
  logic [STEP_W-1:0] rom_step;

  assign rom_op   = (state == DECODE) ? iout : opcode_q;
  assign rom_step = (state == DECODE) ? '0 : step + STEP_W'(1);

  microcode_rom #(.STEP_W(STEP_W), .HLT_OPCODE(HLT_OPCODE)) u_rom (
    .opcode(rom_op),
    .step  (rom_step),
    .word  (rom_word)
  );

  // held marks that the last cycle was a stall; the current state's word is
  // reissued once before the sequence moves on
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RESET;
      step     <= '0;
      word_q   <= IDLE_WORD;
      opcode_q <= '0;
      held     <= 1'b0;
      ctl      <= CTL_IDLE;
      fetching <= 1'b0;
      halted   <= 1'b0;
    end else if (stall && state != HALT) begin
      held     <= 1'b1;
      ctl      <= CTL_IDLE;
      fetching <= 1'b0;
    end else if (held) begin
      held     <= 1'b0;
      ctl      <= (state == FETCH) ? CTL_FETCH : (state == EXEC) ? word_ctl(word_q) : CTL_IDLE;
      fetching <= (state == FETCH);
    end else begin
      case (state)
        RESET: begin
          state    <= FETCH;
          ctl      <= CTL_FETCH;
          fetching <= 1'b1;
        end
        FETCH: begin
          state    <= DECODE;
          ctl      <= CTL_IDLE;
          fetching <= 1'b0;
        end
        DECODE: begin
          state    <= EXEC;
          step     <= '0;
          opcode_q <= iout;
          word_q   <= rom_word;
          ctl      <= word_ctl(rom_word);
        end
        EXEC: begin
          if (word_q[HALT_BIT]) begin
            state  <= HALT;
            ctl    <= CTL_IDLE;
            halted <= 1'b1;
          end else if (word_q[END_BIT] || step == LAST_STEP) begin
            state    <= FETCH;
            step     <= '0;
            ctl      <= CTL_FETCH;
            fetching <= 1'b1;
          end else begin
            step   <= step + STEP_W'(1);
            word_q <= rom_word;
            ctl    <= word_ctl(rom_word);
          end
        end
        default: ctl <= CTL_IDLE;
      endcase
    end
  end

  assign addroutctl  = ctl.addrout;
  assign addrloadctl = ctl.addrload;
  assign outctl      = ctl.outs;
  assign loadctl     = ctl.load;
  assign acincn      = ctl.incn;
  assign acdecn      = ctl.decn;

endmodule

// File: tb/tb_mem_sequencer.sv
// Bench for mem_sequencer: per-instruction expected cycle lists built from the
// instruction rules, replayed against the DUT under random stall/rst.
module tb_mem_sequencer;

  localparam int         MAX_STEPS = 8;
  localparam logic [7:0] HLT       = 8'hFF;
  localparam int K_IDLE = 0, K_FETCH = 1, K_DECODE = 2, K_EXEC = 3, K_HALT = 4;

  logic       clk = 1'b0;
  logic       rst, stall;
  logic [7:0] iout;
  logic [2:0] addroutctl, addrloadctl;
  logic [3:0] outctl, loadctl;
  logic       acincn, acdecn;
  logic [2:0] step;
  logic       fetching, halted;

  typedef struct {
    int aout, aload, outs, load, incn, decn, step, fetching, halted, kind, op;
  } ent_t;

  int         total = 0;
  int         bad = 0;
  ent_t       q[$];
  ent_t       cur;
  bit         held_m = 1'b0;
  logic [7:0] forced[$];

  always #5 clk = ~clk;

  mem_sequencer #(.MAX_STEPS(MAX_STEPS), .HLT_OPCODE(HLT)) dut (
    .clk(clk), .rst(rst), .iout(iout), .stall(stall),
    .addroutctl(addroutctl), .addrloadctl(addrloadctl),
    .outctl(outctl), .loadctl(loadctl),
    .acincn(acincn), .acdecn(acdecn),
    .step(step), .fetching(fetching), .halted(halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  function automatic ent_t mk(int aout, int aload, int outs, int load, bit inc, bit dec,
                              int st, int kind, int op);
    ent_t e;
    e.aout = aout; e.aload = aload; e.outs = outs; e.load = load;
    e.incn = inc ? 0 : 1;
    e.decn = (dec && !inc) ? 0 : 1;
    e.step = st; e.kind = kind; e.op = op;
    e.fetching = (kind == K_FETCH) ? 1 : 0;
    e.halted   = (kind == K_HALT) ? 1 : 0;
    return e;
  endfunction

  function automatic ent_t idle(int st, int kind, int op);
    return mk(7, 7, 0, 0, 1'b0, 1'b0, st, kind, op);
  endfunction

  // Reference microprogram: what each opcode does on execute step k
  task automatic ucode(input int op, input int k, output ent_t e, output bit last, output bit hlt);
    last = 1'b1;
    hlt  = 1'b0;
    e    = idle(k, K_EXEC, op);
    if (op == int'(HLT)) hlt = (k == 0);
    else case (op)
      1: begin
        if (k == 0)      e = mk(5, 7, 9, 11, 1'b1, 1'b0, k, K_EXEC, op);
        else if (k == 1) e = mk(5, 7, 9, 12, 1'b1, 1'b0, k, K_EXEC, op);
        else             e = mk(0, 5, 0, 0, 1'b0, 1'b0, k, K_EXEC, op);
        last = (k >= 2);
      end
      2: begin
        e    = mk(3, 7, 0, 0, 1'b1, 1'b1, k, K_EXEC, op);
        last = 1'b0;
      end
      3: begin
        if (k == 0) e = mk(3, 7, 0, 0, 1'b0, 1'b1, k, K_EXEC, op);
        else        e = mk(3, 7, 9, 11, 1'b0, 1'b0, k, K_EXEC, op);
        last = (k >= 1);
      end
      default: ;
    endcase
  endtask

  task automatic gen_instr();
    int   op, r;
    ent_t e;
    bit   last, hlt;
    if (forced.size() > 0) op = int'(forced.pop_front());
    else begin
      r = $urandom_range(0, 9);
      if (r < 2)       op = 0;
      else if (r < 4)  op = 1;
      else if (r == 4) op = 2;
      else if (r < 7)  op = 3;
      else if (r == 7) op = int'(HLT);
      else             op = $urandom_range(4, 254);
    end
    iout = 8'(op);
    q.push_back(mk(5, 7, 9, 8, 1'b1, 1'b0, 0, K_FETCH, op));
    q.push_back(idle(0, K_DECODE, op));
    for (int k = 0; k < MAX_STEPS; k++) begin
      ucode(op, k, e, last, hlt);
      q.push_back(e);
      if (hlt) begin
        q.push_back(idle(k, K_HALT, op));
        break;
      end
      if (last || k == MAX_STEPS - 1) break;
    end
  endtask

  task automatic advance(input bit rst_v, input bit stall_v, output ent_t want);
    if (rst_v) begin
      q.delete();
      held_m = 1'b0;
      cur    = idle(0, K_IDLE, 0);
      want   = cur;
    end else if (cur.kind == K_HALT) begin
      want = cur;
    end else if (stall_v) begin
      held_m = 1'b1;
      want   = idle(cur.step, K_IDLE, cur.op);
    end else if (held_m) begin
      held_m = 1'b0;
      want   = cur;
    end else begin
      if (q.size() == 0) gen_instr();
      cur  = q.pop_front();
      want = cur;
    end
  endtask

  task automatic cycle(input bit rst_v, input bit stall_v);
    ent_t want;
    rst   = rst_v;
    stall = stall_v;
    @(posedge clk);
    advance(rst_v, stall_v, want);
    #1;
    check("addroutctl", addroutctl, want.aout);
    check("addrloadctl", addrloadctl, want.aload);
    check("outctl", outctl, want.outs);
    check("loadctl", loadctl, want.load);
    check("acincn", acincn, want.incn);
    check("acdecn", acdecn, want.decn);
    check("step", step, want.step);
    check("fetching", fetching, want.fetching);
    check("halted", halted, want.halted);
  endtask

  task automatic run_until(input int kind, input int st, input int op, input int limit);
    int n = 0;
    bit ok;
    ok = (cur.kind == kind && cur.step == st && cur.op == op && !held_m);
    while (!ok && n < limit) begin
      cycle(1'b0, 1'b0);
      n++;
      ok = (cur.kind == kind && cur.step == st && cur.op == op && !held_m);
    end
    check("wait_bound", ok, 1);
  endtask

  initial begin
    int hc = 0;
    rst   = 1'b1;
    stall = 1'b0;
    iout  = 8'h00;
    forced = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, HLT, 8'h01, 8'h02, 8'h03};

    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (12) cycle(1'b0, 1'b0);

    run_until(K_EXEC, 1, 1, 10);
    repeat (4) cycle(1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0);

    run_until(K_HALT, 0, int'(HLT), 20);
    repeat (20) cycle(1'b0, 1'($urandom_range(0, 1)));
    cycle(1'b1, 1'b0);

    run_until(K_EXEC, 2, 1, 10);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);

    run_until(K_EXEC, MAX_STEPS - 1, 2, 20);
    repeat (6) cycle(1'b0, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      hc = (cur.kind == K_HALT) ? hc + 1 : 0;
      cycle(($urandom_range(0, 99) == 0) || hc > 20, $urandom_range(0, 4) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
